// File: rtl/instruction_aligner_pkg.sv
// Shared types for the instruction aligner and the decompressor input stage.
package instruction_aligner_pkg;

   // Aligner buffer state.
   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      HALF     = 2'd1,
      SKIP_LOW = 2'd2
   } align_state_t;

   // Low two bits that mark a full 32-bit instruction.
   localparam logic [1:0] UNCOMP_LOW = 2'b11;

   // One aligned instruction as handed to the decompressor.
   typedef struct packed {
      logic [31:0] data;
      logic [31:0] pc;
      logic        compressed;
   } aligned_instr_t;

   // A halfword starts a compressed instruction unless its low bits are 11.
   function automatic logic is_compressed(input logic [15:0] half);
      return half[1:0] != UNCOMP_LOW;
   endfunction

endpackage

// File: rtl/instruction_aligner_out_reg.sv
// Single-entry valid/ready output register. The payload holds while the
// consumer stalls; flush drops the pending instruction.
module aligner_out_reg
   import instruction_aligner_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   input  logic           load,
   input  logic           emit,
   input  aligned_instr_t in_instr,
   output logic           out_valid,
   output aligned_instr_t out_instr
);

   // Valid follows emit on every load; payload only changes when something is emitted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_instr <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid <= emit;
         if (emit) begin
            out_instr <= in_instr;
         end
      end
   end

endmodule

// File: rtl/instruction_aligner.sv
// Turns word-aligned fetch words into one instruction per handshake,
// stitching 32-bit instructions that straddle a word boundary and
// splitting words that carry two compressed instructions.
module instruction_aligner
   import instruction_aligner_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] fetch_addr,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_data,
   output logic        fetch_ready,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_data,
   output logic [31:0] instr_pc,
   output logic        instr_compressed
);

   localparam logic [31:0]  RESET_FETCH = RESET_PC & ~32'd3;
   localparam logic [31:0]  RESET_NPC   = RESET_PC & ~32'd1;
   localparam align_state_t RESET_STATE = RESET_PC[1] ? SKIP_LOW : EMPTY;

   align_state_t   state;
   align_state_t   state_next;
   logic [15:0]    half_buf;
   logic [15:0]    half_buf_next;
   logic [31:0]    next_pc;
   logic [31:0]    next_pc_next;
   logic [31:0]    fetch_addr_next;
   logic           advance;
   logic           consume;
   logic           emit;
   aligned_instr_t emit_instr;
   aligned_instr_t out_instr;

   assign advance = !instr_valid || instr_ready;

   // Next-state, fetch handshake and instruction assembly; flush overrides everything.
   always_comb begin
      state_next      = state;
      half_buf_next   = half_buf;
      next_pc_next    = next_pc;
      fetch_ready     = 1'b0;
      emit            = 1'b0;
      emit_instr      = '0;
      consume         = 1'b0;
      fetch_addr_next = fetch_addr;

      case (state)
         EMPTY: begin
            fetch_ready = advance;
         end
         HALF: begin
            fetch_ready = is_compressed(half_buf) ? 1'b0 : advance;
         end
         SKIP_LOW: begin
            fetch_ready = advance;
         end
         default: begin
            fetch_ready = 1'b0;
         end
      endcase

      if (flush) begin
         fetch_ready = 1'b0;
      end
      consume = fetch_valid && fetch_ready;

      case (state)
         EMPTY: begin
            if (consume) begin
               emit           = 1'b1;
               emit_instr.pc  = next_pc;
               if (is_compressed(fetch_data[15:0])) begin
                  emit_instr.data       = {16'h0000, fetch_data[15:0]};
                  emit_instr.compressed = 1'b1;
                  half_buf_next         = fetch_data[31:16];
                  next_pc_next          = next_pc + 32'd2;
                  state_next            = HALF;
               end else begin
                  emit_instr.data       = fetch_data;
                  emit_instr.compressed = 1'b0;
                  next_pc_next          = next_pc + 32'd4;
               end
            end
         end
         HALF: begin
            if (is_compressed(half_buf)) begin
               if (advance) begin
                  emit                  = 1'b1;
                  emit_instr.data       = {16'h0000, half_buf};
                  emit_instr.pc         = next_pc;
                  emit_instr.compressed = 1'b1;
                  next_pc_next          = next_pc + 32'd2;
                  state_next            = EMPTY;
               end
            end else if (consume) begin
               emit                  = 1'b1;
               emit_instr.data       = {fetch_data[15:0], half_buf};
               emit_instr.pc         = next_pc;
               emit_instr.compressed = 1'b0;
               half_buf_next         = fetch_data[31:16];
               next_pc_next          = next_pc + 32'd4;
            end
         end
         SKIP_LOW: begin
            if (consume) begin
               half_buf_next = fetch_data[31:16];
               state_next    = HALF;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase

      if (consume) begin
         fetch_addr_next = fetch_addr + 32'd4;
      end

      if (flush) begin
         emit            = 1'b0;
         half_buf_next   = '0;
         next_pc_next    = flush_pc & ~32'd1;
         fetch_addr_next = flush_pc & ~32'd3;
         state_next      = flush_pc[1] ? SKIP_LOW : EMPTY;
      end
   end

   // Aligner state, halfword buffer, fetch address and next-PC registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RESET_STATE;
         half_buf   <= '0;
         next_pc    <= RESET_NPC;
         fetch_addr <= RESET_FETCH;
      end else begin
         state      <= state_next;
         half_buf   <= half_buf_next;
         next_pc    <= next_pc_next;
         fetch_addr <= fetch_addr_next;
      end
   end

   aligner_out_reg u_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .load      (advance),
      .emit      (emit),
      .in_instr  (emit_instr),
      .out_valid (instr_valid),
      .out_instr (out_instr)
   );

   assign instr_data       = out_instr.data;
   assign instr_pc         = out_instr.pc;
   assign instr_compressed = out_instr.compressed;

endmodule

// File: tb/tb_instruction_aligner.sv
// Bench for instruction_aligner: a table of fetch-word scenarios with a
// scoreboard of expected instructions, plus hand-written multi-cycle cases.
module tb_instruction_aligner;

   logic        clk;
   logic        rst_n;
   logic [31:0] fetch_addr;
   logic        fetch_valid;
   logic [31:0] fetch_data;
   logic        fetch_ready;
   logic        flush;
   logic [31:0] flush_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        instr_compressed;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [0:255];
   logic [31:0] win_lo;
   logic [31:0] win_hi;

   typedef struct {
      logic [31:0] data;
      logic [31:0] pc;
      logic        c;
   } exp_t;

   exp_t sb [$];
   exp_t mon_e;

   typedef struct {
      logic [31:0]       start;
      logic [31:0]       w0;
      logic [31:0]       w1;
      int                nw;
      int                ne;
      logic [2:0][31:0]  d;
      logic [2:0][31:0]  p;
      logic [2:0]        c;
   } vec_t;

   vec_t vecs [5];

   instruction_aligner #(.RESET_PC(32'h0000_0000)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .fetch_addr       (fetch_addr),
      .fetch_valid      (fetch_valid),
      .fetch_data       (fetch_data),
      .fetch_ready      (fetch_ready),
      .flush            (flush),
      .flush_pc         (flush_pc),
      .instr_valid      (instr_valid),
      .instr_ready      (instr_ready),
      .instr_data       (instr_data),
      .instr_pc         (instr_pc),
      .instr_compressed (instr_compressed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign fetch_data  = mem[fetch_addr[9:2]];
   assign fetch_valid = (fetch_addr >= win_lo) && (fetch_addr < win_hi);

   // Scoreboard: every accepted instruction must match the head of the queue.
   always @(negedge clk) begin
      if (rst_n && instr_valid && instr_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_instr: got data=%h pc=%h c=%0b, required none",
                     instr_data, instr_pc, instr_compressed);
         end else begin
            mon_e = sb.pop_front();
            if (instr_data !== mon_e.data || instr_pc !== mon_e.pc ||
                instr_compressed !== mon_e.c) begin
               errors++;
               $display("FAIL instr: got data=%h pc=%h c=%0b, required data=%h pc=%h c=%0b",
                        instr_data, instr_pc, instr_compressed, mon_e.data, mon_e.pc, mon_e.c);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic [31:0] p, input logic c);
      exp_t e;
      e.data = d;
      e.pc   = p;
      e.c    = c;
      sb.push_back(e);
   endtask

   // Called at posedge+1: asserts flush for one cycle and opens the fetch window.
   task automatic start(input logic [31:0] pc, input int nw);
      flush    = 1'b1;
      flush_pc = pc;
      win_lo   = pc & ~32'd3;
      win_hi   = (pc & ~32'd3) + 32'(4 * nw);
      #1;
      chk("flush_fetch_ready", {31'd0, fetch_ready}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   task automatic wait_drain(input int max, input bit rnd);
      for (int i = 0; i < max && sb.size() > 0; i++) begin
         @(posedge clk); #1;
         instr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      instr_ready = 1'b1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
         sb.delete();
      end
      repeat (3) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic run_vec(input vec_t v, input bit rnd);
      int idx;
      idx = int'(v.start[9:2]);
      mem[idx]           = v.w0;
      mem[(idx + 1) % 256] = v.w1;
      for (int k = 0; k < v.ne; k++) push(v.d[k], v.p[k], v.c[k]);
      start(v.start, v.nw);
      wait_drain(200, rnd);
   endtask

   function automatic vec_t mkv(input logic [31:0] start_pc, input logic [31:0] w0,
                                input logic [31:0] w1, input int nw, input int ne,
                                input logic [31:0] d0, input logic [31:0] p0, input logic c0,
                                input logic [31:0] d1, input logic [31:0] p1, input logic c1,
                                input logic [31:0] d2, input logic [31:0] p2, input logic c2);
      vec_t v;
      v.start = start_pc;
      v.w0 = w0;
      v.w1 = w1;
      v.nw = nw;
      v.ne = ne;
      v.d  = {d2, d1, d0};
      v.p  = {p2, p1, p0};
      v.c  = {c2, c1, c0};
      return v;
   endfunction

   initial begin
      vecs[0] = mkv(32'h00, 32'h0050_0093, 32'h00A0_0113, 2, 2,
                    32'h0050_0093, 32'h00, 1'b0, 32'h00A0_0113, 32'h04, 1'b0, 32'h0, 32'h0, 1'b0);
      vecs[1] = mkv(32'h10, 32'h4585_4505, 32'h0, 1, 2,
                    32'h0000_4505, 32'h10, 1'b1, 32'h0000_4585, 32'h12, 1'b1, 32'h0, 32'h0, 1'b0);
      vecs[2] = mkv(32'h20, 32'h0093_4505, 32'h4585_0050, 2, 3,
                    32'h0000_4505, 32'h20, 1'b1, 32'h0050_0093, 32'h22, 1'b0, 32'h0000_4585, 32'h26, 1'b1);
      vecs[3] = mkv(32'h102, 32'h0093_0001, 32'h0001_0050, 2, 2,
                    32'h0050_0093, 32'h102, 1'b0, 32'h0000_0001, 32'h106, 1'b1, 32'h0, 32'h0, 1'b0);
      vecs[4] = mkv(32'h40, 32'h0000_FFFF, 32'h0000_0000, 2, 3,
                    32'h0000_FFFF, 32'h40, 1'b0, 32'h0, 32'h44, 1'b1, 32'h0, 32'h46, 1'b1);

      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      rst_n       = 1'b0;
      flush       = 1'b0;
      flush_pc    = 32'h0;
      instr_ready = 1'b1;
      win_lo      = 32'h0;
      win_hi      = 32'h0;

      // Reset values.
      @(negedge clk);
      @(negedge clk);
      chk("rst_fetch_addr", fetch_addr, 32'h0);
      chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr_data", instr_data, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk("rst_instr_c", {31'd0, instr_compressed}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Aligned stream with one-cycle latency.
      mem[0] = 32'h0050_0093;
      mem[1] = 32'h00A0_0113;
      push(32'h0050_0093, 32'h0, 1'b0);
      push(32'h00A0_0113, 32'h4, 1'b0);
      start(32'h0, 2);
      @(negedge clk);
      chk("lat_fetch_ready", {31'd0, fetch_ready}, 32'd1);
      chk("lat_valid_before", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
      chk("lat_valid_after", {31'd0, instr_valid}, 32'd1);
      chk("lat_data", instr_data, 32'h0050_0093);
      wait_drain(50, 1'b0);

      // Two compressed in one word: no fetch while the upper half is emitted.
      mem[4] = 32'h4585_4505;
      push(32'h0000_4505, 32'h10, 1'b1);
      push(32'h0000_4585, 32'h12, 1'b1);
      start(32'h10, 1);
      @(negedge clk);
      @(negedge clk);
      chk("c2_data0", instr_data, 32'h0000_4505);
      chk("c2_fetch_ready", {31'd0, fetch_ready}, 32'd0);
      wait_drain(50, 1'b0);

      // Backpressure on a straddling stream.
      mem[8] = 32'h0093_4505;
      mem[9] = 32'h4585_0050;
      push(32'h0000_4505, 32'h20, 1'b1);
      push(32'h0050_0093, 32'h22, 1'b0);
      push(32'h0000_4585, 32'h26, 1'b1);
      instr_ready = 1'b0;
      start(32'h20, 2);
      @(negedge clk);
      @(negedge clk);
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_data_hold", instr_data, 32'h0000_4505);
         chk("bp_pc_hold", instr_pc, 32'h20);
         chk("bp_fetch_ready", {31'd0, fetch_ready}, 32'd0);
         chk("bp_fetch_addr", fetch_addr, 32'h24);
      end
      @(posedge clk); #1;
      instr_ready = 1'b1;
      wait_drain(50, 1'b0);

      // Misaligned redirect costs one bubble.
      mem[8'h40] = 32'h0093_0001;
      mem[8'h41] = 32'h0001_0050;
      push(32'h0050_0093, 32'h102, 1'b0);
      push(32'h0000_0001, 32'h106, 1'b1);
      start(32'h102, 2);
      @(negedge clk);
      chk("mis_fetch_addr", fetch_addr, 32'h100);
      @(negedge clk);
      chk("mis_bubble", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
      chk("mis_valid", {31'd0, instr_valid}, 32'd1);
      chk("mis_pc", instr_pc, 32'h102);
      wait_drain(50, 1'b0);

      // Table-driven scenarios, first with ready held high, then with random ready.
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 5; i++) run_vec(vecs[i], pass == 1);
      end

      // Reset while a straddle half is buffered and an instruction is stalled.
      mem[0] = 32'h0093_4505;
      instr_ready = 1'b0;
      start(32'h0, 1);
      @(negedge clk);
      @(negedge clk);
      chk("rm_valid_pre", {31'd0, instr_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rm_valid", {31'd0, instr_valid}, 32'd0);
      chk("rm_fetch_addr", fetch_addr, 32'h0);
      chk("rm_data", instr_data, 32'h0);
      mem[0] = 32'h00A0_0113;
      push(32'h00A0_0113, 32'h0, 1'b0);
      @(posedge clk); #1;
      instr_ready = 1'b1;
      rst_n = 1'b1;
      wait_drain(50, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
